// File: rtl/muldiv_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  muldiv_pkg
//  Shared opcodes, FSM state type and register index constants for the
//  mul_div_unit execution block.
//  Revision: 1.0
// ============================================================================
package muldiv_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_UDIV  = 2'b10;
  localparam logic [1:0] OP_SDIV  = 2'b11;

  localparam int XZR_IDX = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  mul_div_unit_if
//  Operand/request bus from the register file read side and result/write
//  strobe bus to the register file write side.
//  Revision: 1.0
// ============================================================================
interface mul_div_unit_if #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_W-1:0]     dataRn;
  logic [DATA_W-1:0]     dataRm;
  logic [REG_ADDR_W-1:0] RdIn;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     result;
  logic [REG_ADDR_W-1:0] RdOut;
  logic                  regWR;

  modport master (
    output start, op, dataRn, dataRm, RdIn,
    input  busy, done, result, RdOut, regWR
  );

  modport slave (
    input  start, op, dataRn, dataRm, RdIn,
    output busy, done, result, RdOut, regWR
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  muldiv_datapath
//  Radix-2 shift-add multiplier / restoring divider sharing one hi/lo pair.
//  Revision: 1.0
// ============================================================================
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_load,
  input  wire logic              i_step,
  input  wire logic              i_finish,
  input  wire logic [1:0]        i_op,
  input  wire logic [DATA_W-1:0] i_a,
  input  wire logic [DATA_W-1:0] i_b,
  output logic                   o_zero_op,
  output logic [DATA_W-1:0]      o_result
);

  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_m;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_neg;
  logic              r_zero;
  logic [DATA_W-1:0] r_result;

  logic              w_sdiv;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shift;
  logic              w_ge;
  logic [DATA_W-1:0] w_hi_n;
  logic [DATA_W-1:0] w_lo_n;
  logic [DATA_W-1:0] w_final;

  assign o_zero_op = (i_a == '0) || (i_b == '0);
  assign w_sdiv    = (i_op == OP_SDIV);
  assign w_a_mag   = (w_sdiv && i_a[DATA_W-1]) ? -i_a : i_a;
  assign w_b_mag   = (w_sdiv && i_b[DATA_W-1]) ? -i_b : i_b;

  // Multiply: hi accumulates, lo holds the multiplier and collects low product bits.
  // Divide:   hi is the partial remainder, lo shifts dividend out and quotient in.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
  assign w_shift = {r_hi, r_lo[DATA_W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_m});

  always_comb begin
    w_hi_n = w_sum[DATA_W:1];
    w_lo_n = {w_sum[0], r_lo[DATA_W-1:1]};
    if (r_op[1]) begin
      w_hi_n = w_ge ? DATA_W'(w_shift - {1'b0, r_m}) : w_shift[DATA_W-1:0];
      w_lo_n = {r_lo[DATA_W-2:0], w_ge};
    end
  end

  always_comb begin
    w_final = w_lo_n;
    case (r_op)
      OP_UMULH: w_final = w_hi_n;
      OP_SDIV:  w_final = r_neg ? -w_lo_n : w_lo_n;
      default:  w_final = w_lo_n;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_MUL;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg    <= 1'b0;
      r_zero   <= 1'b0;
      r_result <= '0;
    end else if (i_load) begin
      r_op   <= i_op;
      r_hi   <= '0;
      r_m    <= i_op[1] ? w_b_mag : i_a;
      r_lo   <= i_op[1] ? w_a_mag : i_b;
      r_neg  <= w_sdiv && (i_a[DATA_W-1] ^ i_b[DATA_W-1]);
      r_zero <= o_zero_op;
    end else if (i_step) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
      // A zero operand always yields zero, which also covers divide-by-zero.
      if (i_finish) begin
        r_result <= r_zero ? '0 : w_final;
      end
    end
  end

  assign o_result = r_result;

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  mul_div_unit
//  Iterative MUL/UMULH/UDIV/SDIV unit feeding the register file write port.
//  Optional: define MULDIV_EARLY_OUT_EN to finish in one CALC cycle on a
//  zero operand.
//  Revision: 1.0
// ============================================================================
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 7
) (
  input wire logic       Clk,
  input wire logic       Rst_n,
  mul_div_unit_if.slave  bus
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit c_EARLY_OUT = 1'b1;
`else
  localparam bit c_EARLY_OUT = 1'b0;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_early;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_step;
  logic                  w_zero_op;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        if ((r_cnt == '0) || r_early) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_accept    = bus.start;
        w_state_nxt = bus.start ? ST_CALC : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_early <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt   <= CNT_W'(DATA_W - 1);
        r_rd    <= bus.RdIn;
        r_early <= c_EARLY_OUT && w_zero_op;
      end else if (w_last) begin
        r_cnt   <= '0;
        r_early <= 1'b0;
      end else if (r_state == ST_CALC) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign w_step = (r_state == ST_CALC);

  muldiv_datapath #(
    .DATA_W (DATA_W)
  ) u_datapath (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .i_load    (w_accept),
    .i_step    (w_step),
    .i_finish  (w_last),
    .i_op      (bus.op),
    .i_a       (bus.dataRn),
    .i_b       (bus.dataRm),
    .o_zero_op (w_zero_op),
    .o_result  (bus.result)
  );

  assign bus.busy  = (r_state == ST_CALC);
  assign bus.done  = (r_state == ST_DONE);
  assign bus.RdOut = r_rd;
  // XZR is never written.
  assign bus.regWR = (r_state == ST_DONE) && (r_rd != REG_ADDR_W'(XZR_IDX));

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Multi-cycle integer multiply/divide execution unit. It sits directly downstream of the register file: it consumes the dataRn/dataRm read operands and a destination index, then produces a result, destination index and write strobe that drive the register file write port (dataWrite/Rd/regWR). It covers the LEGv8 MUL, UMULH, UDIV and SDIV operations with an iterative radix-2 datapath, one bit per cycle.

Parameters:
DATA_W, 64, operand/result width in bits
REG_ADDR_W, 5, register index width
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > DATA_W

Ports:
Clk  input  1  sole clock; all state updates on rising edge
Rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled on rising edge when unit is ready
op  input  2  00 MUL (low product), 01 UMULH (high unsigned product), 10 UDIV, 11 SDIV
dataRn  input  DATA_W  operand A (multiplicand/dividend)
dataRm  input  DATA_W  operand B (multiplier/divisor)
RdIn  input  REG_ADDR_W  destination register for this operation
busy  output  1  high while iterating; start is ignored when high
done  output  1  one-cycle pulse when result is valid
result  output  DATA_W  result; held stable from done until the next accepted start
RdOut  output  REG_ADDR_W  destination captured at start
regWR  output  1  write strobe to register file = done AND (RdOut != 31)

Behaviour:
- Interface decision: one clock (Clk); reset is asynchronous and active-low (Rst_n).
- Reset (assert at any time, including mid-operation): state IDLE; busy=0, done=0, regWR=0, result=0, RdOut=0, counter=0; in-flight operation discarded, no write issued.
- States: IDLE, CALC, DONE.
- IDLE: start=1 -> latch op, RdIn, operands; counter=DATA_W-1; go CALC. start=0 -> stay.
- CALC: busy=1; one iteration per edge; at counter==0 the final iteration completes -> DONE; otherwise counter decrements.
- DONE: done=1 for exactly one cycle, busy=0; start=1 here is accepted (back-to-back, same as IDLE) -> CALC; else -> IDLE.
- Latency: start sampled at edge T0; done high in the cycle after edge T0+DATA_W (64 CALC cycles at default).
- start while in CALC: ignored, no queueing; latched operands unaffected by input changes after T0.
- MUL/UMULH: shift-add over 2*DATA_W product; MUL returns bits [DATA_W-1:0] (sign-agnostic), UMULH returns bits [2*DATA_W-1:DATA_W] unsigned.
- UDIV: restoring division, quotient returned, remainder discarded.
- SDIV: divide magnitudes unsigned; negate quotient when operand signs differ; truncate toward zero.
- Divide by zero (UDIV/SDIV, dataRm=0): result=0, normal latency, no error flag.
- SDIV overflow (most-negative / -1): result = most-negative value (0x8000_0000_0000_0000).
- RdIn=31: operation runs, done pulses, regWR stays 0 (XZR never written).
- regWR/result/RdOut are posedge-generated and stable through the negedge at which the register file writes.

Optional Feature:
MULDIV_EARLY_OUT_EN: when defined, a zero operand at start (either operand for MUL/UMULH; dataRn=0 or dataRm=0 for UDIV/SDIV) makes CALC last exactly one cycle, so done is high in the cycle after edge T0+1; result per normal rules (0). When undefined, every operation takes the full DATA_W iterations regardless of operands.

Decomposition:
- Package muldiv_pkg: op encodings (OP_MUL, OP_UMULH, OP_UDIV, OP_SDIV), state enum (ST_IDLE, ST_CALC, ST_DONE), XZR_IDX=31.
- One sub-module: muldiv_datapath (accumulator/quotient shift registers, one-step add/subtract, sign fix-up); mul_div_unit keeps FSM, counter and handshake.

Test Plan:
- MUL 7 x 6, RdIn=3 -> done pulse 65 cycles after start cycle, result=42, RdOut=3, regWR=1 for one cycle; busy high for 64 cycles.
- UMULH 0xFFFF_FFFF_FFFF_FFFF x 2 -> result=1; MUL same operands -> 0xFFFF_FFFF_FFFF_FFFE.
- UDIV 100/7 -> 14; SDIV -100/7 -> 0xFFFF_FFFF_FFFF_FFF2 (-14); SDIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
- UDIV 5/0 -> result=0 at normal latency (with MULDIV_EARLY_OUT_EN: done in cycle after T0+1); start pulsed mid-CALC -> ignored.
- Back-to-back: start held high through DONE -> second op accepted at DONE, second done exactly 65 cycles later; RdIn=31 -> done=1, regWR=0.
- Rst_n low at CALC cycle 30 -> immediate busy=0, result=0; no done/regWR afterwards; fresh start after release completes correctly.
